// File: rtl/booth_seq_mul.sv
// Iterative radix-4 Booth multiplier, one transaction in flight, valid/ready on both sides.
// Optional `ovf` output (product does not fit WIDTH bits) enabled by BOOTH_MUL_OVF_EN.
module booth_seq_mul #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
`ifdef BOOTH_MUL_OVF_EN
    ,
    output logic                 ovf
`endif
);

    localparam int EW   = WIDTH + 2;
    localparam int AW   = 2 * WIDTH + 4;
    localparam int SW   = WIDTH + 4;
    localparam int ITER = WIDTH / 2 + 1;
    localparam int CW   = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [EW-1:0]        r_mcand;
    logic [AW-1:0]        r_acc;
    logic                 r_prev;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [2*WIDTH-1:0]   r_product;

    logic [EW-1:0]        w_a_ext;
    logic [EW-1:0]        w_b_ext;
    logic [2:0]           w_trip;
    logic [SW-1:0]        w_up;
    logic [SW-1:0]        w_m1;
    logic [SW-1:0]        w_m2;
    logic [SW-1:0]        w_pp;
    logic [SW-1:0]        w_sum;
    logic [AW-1:0]        w_acc_nxt;
    logic [2*WIDTH-1:0]   w_res;
    logic                 w_last;

    // One extra sign/zero bit pair lets the same signed datapath cover unsigned operands.
    assign w_a_ext = {{2{is_signed & a[WIDTH-1]}}, a};
    assign w_b_ext = {{2{is_signed & b[WIDTH-1]}}, b};

    assign w_trip = {r_acc[1:0], r_prev};
    assign w_up   = {{2{r_acc[AW-1]}}, r_acc[AW-1:EW]};
    assign w_m1   = {{2{r_mcand[EW-1]}}, r_mcand};
    assign w_m2   = {r_mcand[EW-1], r_mcand, 1'b0};

    always_comb begin
        w_pp = '0;
        case (w_trip)
            3'b001, 3'b010: w_pp = w_m1;
            3'b011:         w_pp = w_m2;
            3'b100:         w_pp = -w_m2;
            3'b101, 3'b110: w_pp = -w_m1;
            default:        w_pp = '0;
        endcase
    end

    // Sum is two bits wider than the upper half; the shift by 2 brings it back.
    assign w_sum     = w_up + w_pp;
    assign w_acc_nxt = {w_sum, r_acc[EW-1:2]};
    assign w_res     = w_acc_nxt[2*WIDTH-1:0];
    assign w_last    = (r_cnt == CW'(ITER - 1));

`ifdef BOOTH_MUL_OVF_EN
    logic                 r_signed;
    logic                 r_ovf;
    logic                 w_ovf;
    logic [WIDTH:0]       w_shi;

    assign w_shi = w_res[2*WIDTH-1:WIDTH-1];
    assign w_ovf = r_signed ? ~((&w_shi) | ~(|w_shi))
                            : (|w_res[2*WIDTH-1:WIDTH]);
    assign ovf   = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_signed <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (r_state == S_IDLE && in_valid) begin
                r_signed <= is_signed;
            end
            if (r_state == S_BUSY && w_last) begin
                r_ovf <= w_ovf;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_acc       <= '0;
            r_prev      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_product   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mcand    <= w_a_ext;
                        r_acc      <= {{(AW-EW){1'b0}}, w_b_ext};
                        r_prev     <= 1'b0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_acc  <= w_acc_nxt;
                    r_prev <= r_acc[1];
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_product   <= w_res;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign product   = r_product;

endmodule

// File: tb/tb_booth_seq_mul.sv
// Self-checking bench for booth_seq_mul at WIDTH=32 and WIDTH=6 against an arithmetic model.
module tb_booth_seq_mul;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, is_signed, out_valid, out_ready;
    logic [31:0] a, b;
    logic [63:0] product;

    logic        in_valid6, in_ready6, is_signed6, out_valid6, out_ready6;
    logic [5:0]  a6, b6;
    logic [11:0] product6;

`ifdef BOOTH_MUL_OVF_EN
    logic        ovf, ovf6;
`endif

    int n_pass  = 0;
    int n_total = 0;

    booth_seq_mul #(.WIDTH(32)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed),
        .out_valid(out_valid), .out_ready(out_ready),
        .product(product)
`ifdef BOOTH_MUL_OVF_EN
        , .ovf(ovf)
`endif
    );

    booth_seq_mul #(.WIDTH(6)) u_dut6 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid6), .in_ready(in_ready6),
        .a(a6), .b(b6), .is_signed(is_signed6),
        .out_valid(out_valid6), .out_ready(out_ready6),
        .product(product6)
`ifdef BOOTH_MUL_OVF_EN
        , .ovf(ovf6)
`endif
    );

    function automatic logic [63:0] model32(input logic [31:0] x, input logic [31:0] y,
                                            input logic s);
        longint px, py;
        px = s ? longint'($signed(x)) : longint'({32'b0, x});
        py = s ? longint'($signed(y)) : longint'({32'b0, y});
        return 64'(px * py);
    endfunction

    function automatic logic ovf32(input logic [31:0] x, input logic [31:0] y,
                                   input logic s);
        logic [63:0] p;
        longint      sp;
        p  = model32(x, y, s);
        sp = longint'(p);
        if (s) return (sp < -longint'(64'h8000_0000)) || (sp > longint'(64'h7FFF_FFFF));
        return p > 64'hFFFF_FFFF;
    endfunction

    function automatic logic [11:0] model6(input logic [5:0] x, input logic [5:0] y,
                                           input logic s);
        int px, py;
        px = s ? int'($signed(x)) : int'({26'b0, x});
        py = s ? int'($signed(y)) : int'({26'b0, y});
        return 12'(px * py);
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Offers one operand set, waits for accept, then counts edges until out_valid.
    task automatic run32(input logic [31:0] x, input logic [31:0] y, input logic s,
                         output logic [63:0] p, output int lat);
        int n;
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        is_signed = s;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        p = product;
    endtask

    task automatic take32();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_valid6 = 1'b0; out_ready6 = 1'b0;
        a = '0; b = '0; is_signed = 1'b0;
        a6 = '0; b6 = '0; is_signed6 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 64'h0 ||
            in_ready6 !== 1'b1 || out_valid6 !== 1'b0 || product6 !== 12'h0)
            $display("FAIL reset: in_ready=%b out_valid=%b product=%h p6=%h, want 1 0 0 0",
                     in_ready, out_valid, product, product6);
        else n_pass++;
`ifdef BOOTH_MUL_OVF_EN
        n_total++;
        if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf);
        else n_pass++;
`endif
        rst = 1'b0;
    endtask

    task automatic test_signed();
        logic [31:0] xs[3] = '{32'd5, -32'sd6, -32'sd2147483647};
        logic [31:0] ys[3] = '{-32'sd3, -32'sd4, 32'd2};
        logic [63:0] es[3] = '{-64'sd15, 64'd24, 64'hFFFF_FFFF_0000_0002};
        logic [63:0] p;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            run32(xs[i], ys[i], 1'b1, p, lat);
            n_total++;
            if (p !== es[i]) $display("FAIL signed_%0d: got %h want %h", i, p, es[i]);
            else n_pass++;
            n_total++;
            if (lat != 17) $display("FAIL latency_%0d: got %0d want 17", i, lat);
            else n_pass++;
            take32();
        end
    endtask

    task automatic test_unsigned();
        logic [31:0] xs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic        ss[3] = '{1'b0, 1'b1, 1'b1};
        logic [63:0] es[3] = '{64'hFFFF_FFFE_0000_0001, 64'h1, 64'h4000_0000_0000_0000};
        logic [63:0] p;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            run32(xs[i], xs[i], ss[i], p, lat);
            n_total++;
            if (p !== es[i]) $display("FAIL mode_%0d: got %h want %h", i, p, es[i]);
            else n_pass++;
            take32();
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] p;
        int          lat;
        int          bad;
        run32(32'd1234, 32'd5678, 1'b0, p, lat);
        n_total++;
        if (p !== 64'd7006652) $display("FAIL bp_product: got %0d want 7006652", p);
        else n_pass++;
        in_valid = 1'b1; a = 32'd3; b = 32'd3; is_signed = 1'b0;
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (product !== p || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL bp_hold: %0d unstable cycles, want 0", bad);
        else n_pass++;
        in_valid = 1'b0;
        take32();
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL bp_no_accept: in_ready=%b want 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_reset_midop();
        logic [63:0] p;
        int          lat;
        in_valid = 1'b1; a = 32'd123; b = 32'd456; is_signed = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || product !== 64'h0 || in_ready !== 1'b1)
            $display("FAIL rst_busy: out_valid=%b product=%h in_ready=%b want 0 0 1",
                     out_valid, product, in_ready);
        else n_pass++;
        run32(32'd7, 32'd9, 1'b0, p, lat);
        n_total++;
        if (p !== 64'd63 || lat != 17) $display("FAIL after_rst: got %0d lat %0d want 63 17", p, lat);
        else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || product !== 64'h0 || in_ready !== 1'b1)
            $display("FAIL rst_done: out_valid=%b product=%h in_ready=%b want 0 0 1",
                     out_valid, product, in_ready);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] q[$];
        logic [63:0] pcap, e;
        logic        fi, fo;
        int          cyc, sent, got, last;
        cyc = 0; sent = 0; got = 0; last = -1;
        in_valid = 1'b1; out_ready = 1'b1;
        a = pick32(); b = pick32(); is_signed = 1'($urandom);
        while (got < 4 && cyc < 300) begin
            fi   = in_valid && in_ready;
            fo   = out_valid && out_ready;
            pcap = product;
            @(posedge clk); #1;
            cyc++;
            if (fi) begin
                q.push_back(model32(a, b, is_signed));
                sent++;
                if (sent < 4) begin
                    a = pick32(); b = pick32(); is_signed = 1'($urandom);
                end else in_valid = 1'b0;
            end
            if (fo) begin
                e = (q.size() > 0) ? q.pop_front() : 64'hx;
                n_total++;
                if (pcap !== e) $display("FAIL b2b_%0d: got %h want %h", got, pcap, e);
                else n_pass++;
                if (last >= 0) begin
                    n_total++;
                    if (cyc - last != 19) $display("FAIL b2b_gap: got %0d want 19", cyc - last);
                    else n_pass++;
                end
                last = cyc;
                got++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_total++;
        if (got != 4) $display("FAIL b2b_count: got %0d results want 4", got);
        else n_pass++;
    endtask

    task automatic test_random32();
        logic [31:0] x, y;
        logic        s, ok;
        logic [63:0] p, e;
        int          lat, k;
        for (int i = 0; i < 1500; i++) begin
            x = pick32(); y = pick32(); s = 1'($urandom);
            e = model32(x, y, s);
            run32(x, y, s, p, lat);
            ok = (p === e) && (lat == 17);
`ifdef BOOTH_MUL_OVF_EN
            ok = ok && (ovf === ovf32(x, y, s));
`endif
            k = $urandom_range(0, 3);
            repeat (k) begin
                @(posedge clk); #1;
                if (product !== p || out_valid !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
            end
            take32();
            if (out_valid !== 1'b0 || in_ready !== 1'b1) ok = 1'b0;
            n_total++;
            if (!ok) $display("FAIL rand32_%0d: %h*%h s=%b got %h lat %0d want %h lat 17",
                              i, x, y, s, p, lat, e);
            else n_pass++;
        end
    endtask

    task automatic test_random6();
        logic [5:0]  x, y;
        logic        s, ok;
        logic [11:0] e, p;
        int          n, k;
        for (int i = 0; i < 600; i++) begin
            x = 6'($urandom); y = 6'($urandom); s = 1'($urandom);
            e = model6(x, y, s);
            in_valid6 = 1'b1; a6 = x; b6 = y; is_signed6 = s;
            @(posedge clk); #1;
            in_valid6 = 1'b0; a6 = 6'($urandom); b6 = 6'($urandom);
            n = 0;
            while (!out_valid6 && n < 50) begin
                @(posedge clk); #1; n++;
            end
            p  = product6;
            ok = (p === e) && (n == 4);
            k = $urandom_range(0, 2);
            repeat (k) begin
                @(posedge clk); #1;
                if (product6 !== p || out_valid6 !== 1'b1) ok = 1'b0;
            end
            out_ready6 = 1'b1;
            @(posedge clk); #1;
            out_ready6 = 1'b0;
            if (out_valid6 !== 1'b0 || in_ready6 !== 1'b1) ok = 1'b0;
            n_total++;
            if (!ok) $display("FAIL rand6_%0d: %h*%h s=%b got %h lat %0d want %h lat 4",
                              i, x, y, s, p, n, e);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_signed();
        test_unsigned();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        test_random32();
        test_random6();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
